vram_row_reader: RTL and testbench

VRAM_ROW_READER -- requirements
Module: vram_row_reader

---
 rtl/vram_row_reader_pkg.sv | 18 +
 rtl/vram_row_serializer.sv | 60 ++++++
 rtl/vram_row_reader.sv | 104 ++++++++++
 tb/tb_vram_row_reader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_row_reader_pkg.sv
// Shared frame geometry and scan FSM encoding, used by the row reader and the
// frame-buffer side so both agree on row width and pixel packing.
package vram_row_reader_pkg;

  localparam int VRAM_ROWS  = 64;
  localparam int VRAM_COLS  = 64;
  localparam int VRAM_PIX_W = 8;
  localparam int VRAM_ROW_W = VRAM_COLS * VRAM_PIX_W;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_e;

endpackage

// File: rtl/vram_row_serializer.sv
// Holds one captured frame row and hands it out pixel by pixel over a
// valid/ready handshake, tracking the current column.
module vram_row_serializer
  import vram_row_reader_pkg::*;
#(
  parameter int COLS  = VRAM_COLS,
  parameter int PIX_W = VRAM_PIX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  active_i,
  input  logic [COLS*PIX_W-1:0] row_data_i,
  input  logic                  pix_ready_i,
  output logic [PIX_W-1:0]      pix_data_o,
  output logic                  pix_valid_o,
  output logic [CNT_W-1:0]      col_o,
  output logic                  last_xfer_o
);

  // Handshake: a pixel moves only on a cycle where pix_valid_o and pix_ready_i
  // are both 1; while ready is low, data and column hold unchanged.
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);

  logic [COLS*PIX_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]      col_q, col_d;
  logic                  xfer;

  assign pix_valid_o = active_i;
  assign xfer        = active_i & pix_ready_i;
  assign last_xfer_o = xfer & (col_q == LAST_COL);
  assign pix_data_o  = buf_q[PIX_W-1:0];
  assign col_o       = col_q;

  always_comb begin
    buf_d = buf_q;
    col_d = col_q;
    if (clear_i) begin
      col_d = '0;
    end
    if (load_i) begin
      buf_d = row_data_i;
    end else if (xfer) begin
      buf_d = buf_q >> PIX_W;
      col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      col_q <= '0;
    end else begin
      buf_q <= buf_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/vram_row_reader.sv
// Scans a whole frame out of a registered-read frame buffer one row at a time,
// streaming the pixels of each row through the serializer.
module vram_row_reader
  import vram_row_reader_pkg::*;
#(
  parameter int ROWS  = VRAM_ROWS,
  parameter int COLS  = VRAM_COLS,
  parameter int PIX_W = VRAM_PIX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rd,
  output logic [CNT_W-1:0]      rd_addr,
  input  logic [COLS*PIX_W-1:0] row_data,
  output logic [PIX_W-1:0]      pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [CNT_W-1:0]      pix_x,
  output logic [CNT_W-1:0]      pix_y,
  output logic                  row_done,
  output logic                  frame_done,
  output logic                  busy,
  output state_e                dbg_state
);

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             clear_col;
  logic             load_row;
  logic             last_xfer;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    clear_col = 1'b0;
    load_row  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d     = '0;
          clear_col = 1'b1;
          state_d   = REQ;
        end
      end
      REQ:  state_d = LOAD;
      LOAD: begin
        load_row = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (last_xfer) begin
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  vram_row_serializer #(
    .COLS  (COLS),
    .PIX_W (PIX_W)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_col),
    .load_i      (load_row),
    .active_i    (state_q == SHIFT),
    .row_data_i  (row_data),
    .pix_ready_i (pix_ready),
    .pix_data_o  (pix_data),
    .pix_valid_o (pix_valid),
    .col_o       (pix_x),
    .last_xfer_o (last_xfer)
  );

  // Pulses are masked by rst so a pixel discarded by reset reports no completion.
  assign row_done   = last_xfer & ~rst;
  assign frame_done = last_xfer & (row_q == LAST_ROW) & ~rst;

  assign rd        = (state_q == REQ);
  assign rd_addr   = row_q;
  assign pix_y     = row_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_row_reader.sv
// Self-checking bench for vram_row_reader: frame-buffer model, randomized
// backpressure, expected-pixel scoreboard and directed corner scenarios.
module tb_vram_row_reader;
  import vram_row_reader_pkg::*;

  localparam int ROWS  = VRAM_ROWS;
  localparam int COLS  = VRAM_COLS;
  localparam int PIX_W = VRAM_PIX_W;
  localparam int ROW_W = VRAM_ROW_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             rd;
  logic [5:0]       rd_addr;
  logic [ROW_W-1:0] row_data = '0;
  logic [7:0]       pix_data;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic [5:0]       pix_x, pix_y;
  logic             row_done, frame_done, busy;
  state_e           dbg_state;

  vram_row_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rd         (rd),
    .rd_addr    (rd_addr),
    .row_data   (row_data),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .row_done   (row_done),
    .frame_done (frame_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // expected pixel entries: {y[5:0], x[5:0], value[7:0]}
  logic [19:0] exp_q[$];

  int   ready_mode   = 0;   // 0 always, 1 toggle, 2 random, 3 manual
  logic manual_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame buffer model (1-cycle registered read) ----------------
  function automatic logic [ROW_W-1:0] fb_row(input logic [5:0] r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*PIX_W +: PIX_W] = 8'((int'(r) + c) % 256);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rd) row_data <= fb_row(rd_addr);
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      2:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = manual_ready;
    endcase
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a frame is every (row, col) in raster order, value (row+col) mod 256.
  task automatic push_frame();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        exp_q.push_back({6'(y), 6'(x), 8'((y + x) % 256)});
  endtask

  task automatic start_frame();
    drive_edge();
    start = 1'b1;
    push_frame();
    drive_edge();
    start = 1'b0;
  endtask

  task automatic wait_frame(input int bound, output int cyc);
    cyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      cyc = i + 1;
      if (frame_done) break;
    end
    if (!frame_done) check("frame_done_timeout", 32'(frame_done), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"}, 32'(rd), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check({tag, "_pix_data"}, 32'(pix_data), 0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check({tag, "_pix_x"}, 32'(pix_x), 0);
    check({tag, "_pix_y"}, 32'(pix_y), 0);
    check({tag, "_row_done"}, 32'(row_done), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic [5:0]  prev_x, prev_y;
  logic [19:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(pix_valid), 1);
        check("stall_data", 32'(pix_data), 32'(prev_data));
        check("stall_x", 32'(pix_x), 32'(prev_x));
        check("stall_y", 32'(pix_y), 32'(prev_y));
      end
      if (rd) begin
        if (exp_q.size() == 0) check("rd_unexpected", 32'(rd), 0);
        else check("rd_addr", 32'(rd_addr), 32'(exp_q[0][19:14]));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 32'(pix_valid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pix_y", 32'(pix_y), 32'(mon_e[19:14]));
          check("pix_x", 32'(pix_x), 32'(mon_e[13:8]));
          check("pix_data", 32'(pix_data), 32'(mon_e[7:0]));
          check("row_done", 32'(row_done), 32'(mon_e[13:8] == 6'd63));
          check("frame_done", 32'(frame_done),
                32'(mon_e[13:8] == 6'd63 && mon_e[19:14] == 6'd63));
          if (mon_e[19:14] == 6'd5 && mon_e[13:8] == 6'd10)
            check("pix_r5c10", 32'(pix_data), 32'h0F);
        end
      end else begin
        check("pulse_no_xfer", 32'({row_done, frame_done}), 0);
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_x     = pix_x;
      prev_y     = pix_y;
    end
  end

  // ---------------- scenarios ----------------
  initial begin
    int cyc;
    int guard;

    repeat (3) drive_edge();
    @(negedge clk);
    check_all_zero("reset");
    drive_edge();
    rst = 1'b0;

    // Full frame with ready always high: latency and total frame time
    ready_mode = 0;
    drive_edge();
    start = 1'b1;
    push_frame();
    drive_edge();
    start = 1'b0;
    @(negedge clk);
    check("c1_rd", 32'(rd), 1);
    check("c1_rd_addr", 32'(rd_addr), 0);
    check("c1_busy", 32'(busy), 1);
    check("c1_valid", 32'(pix_valid), 0);
    @(negedge clk);
    check("c2_rd", 32'(rd), 0);
    check("c2_valid", 32'(pix_valid), 0);
    @(negedge clk);
    check("c3_valid", 32'(pix_valid), 1);
    check("c3_data", 32'(pix_data), 0);
    check("c3_x", 32'(pix_x), 0);
    check("c3_y", 32'(pix_y), 0);
    wait_frame(6000, cyc);
    check("frame_cycles", 32'(cyc + 3), 32'(ROWS * (COLS + 2)));
    @(negedge clk);
    check("s1_busy_after", 32'(busy), 0);
    check("s1_queue_empty", 32'(exp_q.size()), 0);

    // ready toggling every cycle
    ready_mode = 1;
    start_frame();
    wait_frame(20000, cyc);
    @(negedge clk);
    check("s2_queue_empty", 32'(exp_q.size()), 0);

    // Stall on the last column of row 0
    ready_mode   = 3;
    manual_ready = 1'b1;
    start_frame();
    guard = 0;
    while (!(pix_valid && pix_x == 6'd62 && pix_y == 6'd0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("s3_reach_col62", 32'(pix_x), 62);
    manual_ready = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("s3_stall_rd", 32'(rd), 0);
      check("s3_stall_row_done", 32'(row_done), 0);
      check("s3_stall_x", 32'(pix_x), 63);
    end
    manual_ready = 1'b1;
    @(negedge clk);
    check("s3_row_done", 32'(row_done), 1);
    @(negedge clk);
    check("s3_rd", 32'(rd), 1);
    check("s3_rd_addr", 32'(rd_addr), 1);
    ready_mode = 0;
    wait_frame(6000, cyc);
    @(negedge clk);
    check("s3_queue_empty", 32'(exp_q.size()), 0);

    // Reset at row 7 col 30, then restart from row 0 under random ready
    start_frame();
    guard = 0;
    while (!(pix_valid && pix_x == 6'd29 && pix_y == 6'd7) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("s4_reach_r7c29", 32'({pix_y, pix_x}), 32'({6'd7, 6'd29}));
    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_all_zero("post_rst");
    ready_mode = 2;
    start_frame();
    @(negedge clk);
    check("s4_restart_rd", 32'(rd), 1);
    check("s4_restart_addr", 32'(rd_addr), 0);
    wait_frame(20000, cyc);
    @(negedge clk);
    check("s4_queue_empty", 32'(exp_q.size()), 0);

    // start held through the scan and the frame_done cycle
    drive_edge();
    start = 1'b1;
    push_frame();
    wait_frame(20000, cyc);
    drive_edge();
    start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("s5_idle_busy", 32'(busy), 0);
      check("s5_idle_valid", 32'(pix_valid), 0);
    end
    check("s5_queue_empty", 32'(exp_q.size()), 0);
    start_frame();
    @(negedge clk);
    check("s5_rearm_rd", 32'(rd), 1);
    check("s5_rearm_addr", 32'(rd_addr), 0);
    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("s5_final_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
